// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: instruction classes, opcodes and field bit ranges.
// Also holds the two small decode helpers used by the instruction register.
package mips_pkg;

  typedef enum logic [1:0] {
    TYPE_R = 2'b00,
    TYPE_I = 2'b01,
    TYPE_J = 2'b10
  } inst_type_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JA_HI  = 25;
  localparam int JA_LO  = 0;

  // Undefined opcodes fall into the I class; no trap is raised for them.
  function automatic inst_type_e classify(input logic [5:0] op);
    if (op == OP_RTYPE) begin
      return TYPE_R;
    end else if (op == OP_J || op == OP_JAL) begin
      return TYPE_J;
    end
    return TYPE_I;
  endfunction

  function automatic logic is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/inst_queue_reg_fifo.sv
// Prefetch storage for (instruction, PC) pairs with explicit occupancy count.
// Push/pop requests are qualified here against full/empty and flush.
module inst_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          in_ready,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready = (count_q < FULL_CNT);
  assign empty    = (count_q == '0);
  assign rdata    = mem_q[rd_ptr_q];
  assign count    = count_q;

  assign push = wr_en && in_ready && !flush;
  assign pop  = rd_en && !empty && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_queue_reg.sv
// Prefetch queue feeding an ir_w-gated instruction register with MIPS field decode.
// Handshake: a word transfers on a rising edge where in_valid && in_ready are both high.
module inst_queue_reg
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   ir_w,
  output logic                   ir_valid,
  output logic [PC_W-1:0]        ir_pc,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             shamt,
  output logic [5:0]             funct,
  output logic [15:0]            immediate,
  output logic [XLEN-1:0]        imm_ext,
  output logic [25:0]            jump_address,
  output logic [1:0]             inst_type,
  output logic [$clog2(DEPTH):0] count
);

  localparam int W = 32 + PC_W;

  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic [W-1:0]    head;
  logic            fifo_empty;
  logic            bypass;
  logic            wr_en;

  // An empty-queue load consumes the incoming word directly instead of enqueuing it.
  assign bypass = ir_w && fifo_empty && in_valid;
  assign wr_en  = in_valid && !(ir_w && fifo_empty);

  inst_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_en    (wr_en),
    .rd_en    (ir_w),
    .wdata    ({in_pc, in_inst}),
    .rdata    (head),
    .empty    (fifo_empty),
    .in_ready (in_ready),
    .count    (count)
  );

  always_comb begin
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (flush) begin
      ir_valid_d = 1'b0;
    end else if (ir_w) begin
      if (!fifo_empty) begin
        ir_d       = head[31:0];
        ir_pc_d    = head[W-1:32];
        ir_valid_d = 1'b1;
      end else if (bypass) begin
        ir_d       = in_inst;
        ir_pc_d    = in_pc;
        ir_valid_d = 1'b1;
      end else begin
        ir_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign ir_valid     = ir_valid_q;
  assign ir_pc        = ir_pc_q;
  assign opcode       = ir_q[OPC_HI:OPC_LO];
  assign rs           = ir_q[RS_HI:RS_LO];
  assign rt           = ir_q[RT_HI:RT_LO];
  assign rd           = ir_q[RD_HI:RD_LO];
  assign shamt        = ir_q[SH_HI:SH_LO];
  assign funct        = ir_q[FN_HI:FN_LO];
  assign immediate    = ir_q[IMM_HI:IMM_LO];
  assign jump_address = ir_q[JA_HI:JA_LO];
  assign inst_type    = classify(opcode);
  assign imm_ext      = is_zext(opcode) ? XLEN'(immediate) : XLEN'($signed(immediate));

endmodule

// File: tb/tb_inst_queue_reg.sv
// Bench for inst_queue_reg: decode vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_inst_queue_reg;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int XLEN  = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [31:0]            in_inst = '0;
  logic [PC_W-1:0]        in_pc = '0;
  logic                   ir_w = 1'b0;
  logic                   ir_valid;
  logic [PC_W-1:0]        ir_pc;
  logic [5:0]             opcode;
  logic [4:0]             rs, rt, rd, shamt;
  logic [5:0]             funct;
  logic [15:0]            immediate;
  logic [XLEN-1:0]        imm_ext;
  logic [25:0]            jump_address;
  logic [1:0]             inst_type;
  logic [$clog2(DEPTH):0] count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [31:0] m_ir;
  logic [31:0] m_pc;
  logic        m_valid;

  inst_queue_reg #(.DEPTH(DEPTH), .PC_W(PC_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .ir_w(ir_w), .ir_valid(ir_valid), .ir_pc(ir_pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .imm_ext(imm_ext), .jump_address(jump_address),
    .inst_type(inst_type), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] ext;
    logic [1:0]  typ;
    logic [25:0] ja;
  } vec_t;

  vec_t vecs[7];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived arithmetically from the model IR.
  task automatic check_model(input string tag);
    logic [5:0]  e_opc;
    logic [15:0] e_imm;
    logic [31:0] e_ext;
    logic [1:0]  e_typ;
    e_opc = 6'(m_ir >> 26);
    e_imm = 16'(m_ir & 32'hFFFF);
    if (e_opc == 6'h0C || e_opc == 6'h0D || e_opc == 6'h0E) e_ext = {16'h0, e_imm};
    else e_ext = e_imm[15] ? (32'hFFFF0000 | e_imm) : {16'h0, e_imm};
    if (e_opc == 6'h00) e_typ = 2'b00;
    else if (e_opc == 6'h02 || e_opc == 6'h03) e_typ = 2'b10;
    else e_typ = 2'b01;
    check_eq({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(exp_q.size() < DEPTH));
    check_eq({tag, ".ir_valid"}, 64'(ir_valid), 64'(m_valid));
    check_eq({tag, ".ir_pc"}, 64'(ir_pc), 64'(m_pc));
    check_eq({tag, ".opcode"}, 64'(opcode), 64'(e_opc));
    check_eq({tag, ".rs"}, 64'(rs), 64'((m_ir >> 21) % 32));
    check_eq({tag, ".rt"}, 64'(rt), 64'((m_ir >> 16) % 32));
    check_eq({tag, ".rd"}, 64'(rd), 64'((m_ir >> 11) % 32));
    check_eq({tag, ".shamt"}, 64'(shamt), 64'((m_ir >> 6) % 32));
    check_eq({tag, ".funct"}, 64'(funct), 64'(m_ir % 64));
    check_eq({tag, ".immediate"}, 64'(immediate), 64'(e_imm));
    check_eq({tag, ".imm_ext"}, 64'(imm_ext), 64'(e_ext));
    check_eq({tag, ".jump_address"}, 64'(jump_address), 64'(m_ir % (1 << 26)));
    check_eq({tag, ".inst_type"}, 64'(inst_type), 64'(e_typ));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ir = '0;
    m_pc = '0;
    m_valid = 1'b0;
  endtask

  // Apply one clock edge of stimulus; the model follows the behavioural rules directly.
  task automatic step(input logic f, input logic iv, input logic w,
                      input logic [31:0] inst, input logic [31:0] pc);
    logic [63:0] h;
    logic        room;
    flush = f; in_valid = iv; ir_w = w; in_inst = inst; in_pc = pc;
    @(posedge clk);
    room = (exp_q.size() < DEPTH);
    if (f) begin
      exp_q.delete();
      m_valid = 1'b0;
    end else if (w && exp_q.size() > 0) begin
      h = exp_q.pop_front();
      m_ir = h[31:0]; m_pc = h[63:32]; m_valid = 1'b1;
      if (iv && room) exp_q.push_back({pc, inst});
    end else if (w && iv) begin
      m_ir = inst; m_pc = pc; m_valid = 1'b1;
    end else if (w) begin
      m_valid = 1'b0;
    end else if (iv && room) begin
      exp_q.push_back({pc, inst});
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 0; in_valid = 0; ir_w = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] saved_ir_opc;
    vecs[0] = '{32'h012A4020, 32'h00400000, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 32'h00004020, 2'b00, 26'h12A4020};
    vecs[1] = '{32'h3C01FFFF, 32'h00400004, 6'h0F, 5'd0, 5'd1, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'hFFFFFFFF, 2'b01, 26'h001FFFF};
    vecs[2] = '{32'h3421FFFF, 32'h00400008, 6'h0D, 5'd1, 5'd1, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'h0000FFFF, 2'b01, 26'h021FFFF};
    vecs[3] = '{32'h0C100008, 32'h0040000C, 6'h03, 5'd0, 5'd16, 5'd0, 5'd0, 6'h08, 16'h0008, 32'h00000008, 2'b10, 26'h0100008};
    vecs[4] = '{32'h2108FFFC, 32'h00400010, 6'h08, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3C, 16'hFFFC, 32'hFFFFFFFC, 2'b01, 26'h108FFFC};
    vecs[5] = '{32'h38008000, 32'h00400014, 6'h0E, 5'd0, 5'd0, 5'd16, 5'd0, 6'h00, 16'h8000, 32'h00008000, 2'b01, 26'h0008000};
    vecs[6] = '{32'h08000010, 32'h00400018, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 16'h0010, 32'h00000010, 2'b10, 26'h0000010};

    do_reset();
    check_model("reset");

    // Push then load one edge later
    step(0, 1, 0, 32'h012A4020, 32'h00400000);
    check_eq("push1.count", 64'(count), 64'd1);
    step(0, 0, 1, 32'h0, 32'h0);
    check_model("load1");
    check_eq("load1.rd", 64'(rd), 64'd8);

    // Decode table through the bypass path
    foreach (vecs[i]) begin
      step(0, 1, 1, vecs[i].inst, vecs[i].pc);
      check_eq($sformatf("vec%0d.count", i), 64'(count), 64'd0);
      check_eq($sformatf("vec%0d.ir_valid", i), 64'(ir_valid), 64'd1);
      check_eq($sformatf("vec%0d.ir_pc", i), 64'(ir_pc), 64'(vecs[i].pc));
      check_eq($sformatf("vec%0d.opcode", i), 64'(opcode), 64'(vecs[i].opc));
      check_eq($sformatf("vec%0d.rs", i), 64'(rs), 64'(vecs[i].rs));
      check_eq($sformatf("vec%0d.rt", i), 64'(rt), 64'(vecs[i].rt));
      check_eq($sformatf("vec%0d.rd", i), 64'(rd), 64'(vecs[i].rd));
      check_eq($sformatf("vec%0d.shamt", i), 64'(shamt), 64'(vecs[i].sh));
      check_eq($sformatf("vec%0d.funct", i), 64'(funct), 64'(vecs[i].fn));
      check_eq($sformatf("vec%0d.imm", i), 64'(immediate), 64'(vecs[i].imm));
      check_eq($sformatf("vec%0d.imm_ext", i), 64'(imm_ext), 64'(vecs[i].ext));
      check_eq($sformatf("vec%0d.type", i), 64'(inst_type), 64'(vecs[i].typ));
      check_eq($sformatf("vec%0d.jaddr", i), 64'(jump_address), 64'(vecs[i].ja));
      check_model($sformatf("vec%0d", i));
    end

    // Empty queue, ir_w without in_valid: IR holds, invalid
    step(0, 0, 1, 32'h0, 32'h0);
    check_eq("empty_load.ir_valid", 64'(ir_valid), 64'd0);
    check_eq("empty_load.opcode", 64'(opcode), 64'h02);
    check_model("empty_load");

    // Fill to full; fifth word refused
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 32'h20000000 + i, 32'h1000 + 4 * i);
    check_eq("full.count", 64'(count), 64'(DEPTH));
    check_eq("full.in_ready", 64'(in_ready), 64'd0);
    step(0, 1, 0, 32'hDEADBEEF, 32'hBAD);
    check_model("full.reject");
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 32'h0, 32'h0);
      check_eq($sformatf("drain%0d.ir_pc", i), 64'(ir_pc), 64'(32'h1000 + 4 * i));
      check_model($sformatf("drain%0d", i));
    end
    check_eq("drained.count", 64'(count), 64'd0);

    // Flush with three entries, simultaneous ir_w and in_valid ignored
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h3C000000 + i, 32'h2000 + 4 * i);
    saved_ir_opc = 32'(opcode);
    step(1, 1, 1, 32'h012A4020, 32'h3000);
    check_eq("flush.count", 64'(count), 64'd0);
    check_eq("flush.ir_valid", 64'(ir_valid), 64'd0);
    check_eq("flush.in_ready", 64'(in_ready), 64'd1);
    check_eq("flush.opcode_hold", 64'(opcode), 64'(saved_ir_opc));
    check_model("flush");

    // Asynchronous reset mid-cycle
    step(0, 1, 1, 32'h2108FFFC, 32'h4000);
    step(0, 1, 0, 32'h3421FFFF, 32'h4004);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("areset.count", 64'(count), 64'd0);
    check_eq("areset.ir_valid", 64'(ir_valid), 64'd0);
    check_eq("areset.imm_ext", 64'(imm_ext), 64'd0);
    check_model("areset");
    #3 rst_n = 1'b1;

    // Wrap-around with concurrent push and pop at count 2
    step(0, 1, 0, 32'h50000000, 32'h5000);
    step(0, 1, 0, 32'h50000001, 32'h5004);
    for (int i = 2; i < 12; i++) begin
      step(0, 1, 1, 32'h50000000 + i, 32'h5000 + 4 * i);
      check_eq($sformatf("wrap%0d.count", i), 64'(count), 64'd2);
      check_eq($sformatf("wrap%0d.ir_pc", i), 64'(ir_pc), 64'(32'h5000 + 4 * (i - 2)));
      check_model($sformatf("wrap%0d", i));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
           $urandom, $urandom);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_queue_reg.md
Name: inst_queue_reg

Overview:
- Parametrised successor to the multicycle instruction register.
- A DEPTH-entry prefetch queue of (instruction, PC) pairs feeds an architectural instruction register (IR).
- The IR decodes into MIPS fields plus a type class and an extended immediate.
- Sits between the instruction-memory fetch port (valid/ready producer) and the control unit/register file (ir_w consumer).

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PC_W, 32, width of the fetch address stored alongside each instruction.
- XLEN, 32, width of the extended immediate output; at least 16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard the queue and invalidate the IR (branch/jump redirect).
- in_valid  in  1  fetch word present.
- in_ready  out  1  queue can accept a word; equals (count < DEPTH).
- in_inst  in  32  fetched instruction.
- in_pc  in  PC_W  address of in_inst.
- ir_w  in  1  load the IR from the queue head.
- ir_valid  out  1  IR holds a valid instruction.
- ir_pc  out  PC_W  PC of the IR instruction.
- opcode  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- shamt  out  5  IR[10:6].
- funct  out  6  IR[5:0].
- immediate  out  16  IR[15:0].
- imm_ext  out  XLEN  immediate extended to XLEN.
  - Zero-extended when opcode is 0x0C, 0x0D or 0x0E (andi/ori/xori).
  - Sign-extended otherwise.
- jump_address  out  26  IR[25:0].
- inst_type  out  2  00 = R, 01 = I, 10 = J.
- count  out  clog2(DEPTH)+1  number of queue occupants.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Queue empty, count = 0, in_ready = 1.
  - IR = 0, ir_pc = 0, ir_valid = 0.
  - All field outputs are therefore 0, inst_type = 00, imm_ext = 0.
  - Reset mid-transfer discards everything; no partial state survives.
- All outputs are registered or pure decode of the IR register; there is no combinational path from any input to any output.
- Push: an edge with in_valid && in_ready writes (in_inst, in_pc) at the write pointer.
- IR load: an edge with ir_w does one of the following.
  - Queue non-empty: IR and ir_pc take the head entry, the head is popped, ir_valid = 1.
  - Queue empty and in_valid = 1 (bypass): IR takes in_inst/in_pc directly, nothing is enqueued, ir_valid = 1.
  - Queue empty and in_valid = 0: IR value holds, ir_valid = 0.
- Without ir_w, the IR holds its value regardless of queue activity; this is the ir_w-gated latch semantics carried forward.
- Latency:
  - A word pushed at edge N is loadable into the IR by ir_w at edge N+1 or later.
  - The bypass path gives 0 queue cycles.
- Push and pop on the same edge: count unchanged, both pointers advance. Both occur at full only if in_ready was already 1, so never at full.
- Full (count = DEPTH): in_ready = 0; in_valid is ignored.
- Empty with no ir_w: no state change.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy explicitly.
- flush (highest priority):
  - At the edge, the queue is emptied, count = 0, ir_valid = 0.
  - IR field contents hold (not cleared).
  - Any simultaneous push or ir_w is ignored.
- inst_type decode:
  - opcode 0x00 → R.
  - opcode 0x02 or 0x03 → J.
  - Everything else → I.
- Undefined opcodes classify as I; no trap is raised.

Decomposition:
- Shared package mips_pkg holds:
  - inst_type encodings TYPE_R / TYPE_I / TYPE_J.
  - Opcode constants OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI.
  - Field bit-range constants.
- One sub-module, inst_fifo: DEPTH × (32 + PC_W) storage, pointers, count, in_ready.
- Top level holds the IR, bypass mux and decode.

Test Plan:
1. Reset, then push 0x012A4020 (add $8,$9,$10), PC 0x400000; pulse ir_w one cycle later → opcode 0, rs 9, rt 10, rd 8, funct 0x20, inst_type 00, ir_valid 1, ir_pc 0x400000, count 0.
2. Push DEPTH = 4 words with ir_w held low → count 4, in_ready 0; a fifth in_valid is not accepted. Pop all four with ir_w → IR sequence matches push order, count returns to 0.
3. Empty queue: ir_w and in_valid with 0x3C01FFFF (lui) asserted on the same edge → IR loads it via bypass, count stays 0. immediate 0xFFFF, imm_ext 0xFFFFFFFF, inst_type 01.
4. Load 0x3421FFFF (ori) → imm_ext 0x0000FFFF. Load 0x0C100008 (jal) → inst_type 10, jump_address 0x0100008.
5. Queue holding 3 entries; flush asserted together with ir_w and in_valid → count 0, ir_valid 0, IR fields unchanged, in_ready 1. Then pull rst_n low asynchronously mid-cycle → all outputs 0 immediately.
6. Wrap-around: 10 cycles of simultaneous push and pop at count 2 → count stays 2, data order preserved across pointer wrap.
